// File: rtl/wb_pkg.sv
// =====================================================================
// wb_pkg: shared types and constants for the writeback stage (rev 1.0)
// =====================================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam logic [3:0] R15 = 4'hF;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_src;
    logic [3:0] wa3;
  } wb_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/writeback_stage_if.sv
// =====================================================================
// writeback_stage_if: M-side inputs and register-file/fetch outputs (rev 1.0)
// =====================================================================
`default_nettype none

interface writeback_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
);
  logic             ValidM;
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             PCSrcM;
  logic [3:0]       WA3M;
  logic [WIDTH-1:0] ALUOutM;
  logic [WIDTH-1:0] ReadDataM;
  logic             MemRValidM;
  logic             FlushW;
  logic             StallW;
  logic             RegWriteW;
  logic [3:0]       WA3W;
  logic [WIDTH-1:0] ResultW;
  logic             PCSrcW;
  logic [CNTW-1:0]  RetiredW;
  logic             ErrW;

  modport master (
    output ValidM, RegWriteM, MemtoRegM, PCSrcM, WA3M, ALUOutM, ReadDataM,
           MemRValidM, FlushW,
    input  StallW, RegWriteW, WA3W, ResultW, PCSrcW, RetiredW, ErrW
  );

  modport slave (
    input  ValidM, RegWriteM, MemtoRegM, PCSrcM, WA3M, ALUOutM, ReadDataM,
           MemRValidM, FlushW,
    output StallW, RegWriteW, WA3W, ResultW, PCSrcW, RetiredW, ErrW
  );
endinterface

`default_nettype wire

// File: rtl/mux2to1.sv
// =====================================================================
// mux2to1: generic two-input word multiplexer (rev 1.0)
// =====================================================================
`default_nettype none

module mux2to1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

`default_nettype wire

// File: rtl/wb_watchdog.sv
// =====================================================================
// wb_watchdog: load-wait cycle counter with expiry flag (rev 1.0)
// =====================================================================
`default_nettype none

module wb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);
endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// =====================================================================
// writeback_stage: M/W register, result select and load-wait stall FSM (rev 1.0)
// =====================================================================
`default_nettype none

module writeback_stage
  import wb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  bus
);
  typedef struct packed {
    wb_ctrl_t         ctrl;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] read_data;
  } wreg_t;

  wb_state_t        state, state_n;
  wreg_t            wreg, wreg_n;
  logic [CNTW-1:0]  retired;
  logic             err;
  logic             err_set;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expired;
  logic             complete;
  logic             complete_n;
  logic [WIDTH-1:0] result;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_n = state;
    wreg_n  = wreg;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    err_set = 1'b0;
    if (bus.FlushW) begin
      state_n          = IDLE;
      wreg_n.ctrl.valid = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wreg_n.ctrl.valid      = bus.ValidM;
          wreg_n.ctrl.reg_write  = bus.RegWriteM;
          wreg_n.ctrl.mem_to_reg = bus.MemtoRegM;
          wreg_n.ctrl.pc_src     = bus.PCSrcM;
          wreg_n.ctrl.wa3        = bus.WA3M;
          wreg_n.alu_out         = bus.ALUOutM;
          if (bus.ValidM && bus.MemtoRegM && !bus.MemRValidM) begin
            state_n = WAIT_MEM;
            wd_clr  = 1'b1;
          end else begin
            wreg_n.read_data = bus.ReadDataM;
          end
        end
        WAIT_MEM: begin
          if (bus.MemRValidM) begin
            wreg_n.read_data = bus.ReadDataM;
            state_n          = IDLE;
          end else if (wd_expired) begin
            // Unanswered load is dropped: no register write, no retire.
            err_set           = 1'b1;
            wreg_n.ctrl.valid = 1'b0;
            state_n           = IDLE;
          end else begin
            wd_en = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Counting the instruction as it enters a completing W cycle keeps RetiredW
  // in step with the write it reports.
  assign complete_n = wreg_n.ctrl.valid && (state_n == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wreg    <= '0;
      retired <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      wreg  <= wreg_n;
      if (complete_n) begin
        retired <= retired + CNTW'(1);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  mux2to1 #(.WIDTH(WIDTH)) u_result_mux (
    .a   (wreg.alu_out),
    .b   (wreg.read_data),
    .sel (wreg.ctrl.mem_to_reg),
    .y   (result)
  );

  assign complete      = wreg.ctrl.valid && (state == IDLE);
  assign bus.StallW    = (state == WAIT_MEM);
  assign bus.RegWriteW = complete && wreg.ctrl.reg_write;
  assign bus.WA3W      = wreg.ctrl.wa3;
  assign bus.ResultW   = result;
  assign bus.PCSrcW    = complete &&
                         (wreg.ctrl.pc_src || (wreg.ctrl.reg_write && (wreg.ctrl.wa3 == R15)));
  assign bus.RetiredW  = retired;
  assign bus.ErrW      = err;
endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// =====================================================================
// tb_writeback_stage: directed + random checks against a reference model (rev 1.0)
// =====================================================================
`default_nettype none

module tb_writeback_stage;
  localparam int WIDTH   = 8;
  localparam int CNTW    = 16;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_stage_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  writeback_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction sitting in writeback and whether it is waiting on memory.
  bit          m_busy;
  int          m_waited;
  bit          m_valid, m_rw, m_mtr, m_pc, m_err;
  logic [3:0]  m_wa3;
  logic [7:0]  m_alu, m_rd;
  int unsigned m_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rw, input bit mtr, input bit pc,
                       input logic [3:0] wa3, input logic [7:0] alu, input logic [7:0] rd,
                       input bit rv, input bit fl, input bit rs);
    bus.ValidM     = v;
    bus.RegWriteM  = rw;
    bus.MemtoRegM  = mtr;
    bus.PCSrcM     = pc;
    bus.WA3M       = wa3;
    bus.ALUOutM    = alu;
    bus.ReadDataM  = rd;
    bus.MemRValidM = rv;
    bus.FlushW     = fl;
    reset          = rs;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_busy = 0; m_waited = 0; m_valid = 0; m_rw = 0; m_mtr = 0; m_pc = 0;
      m_wa3 = '0; m_alu = '0; m_rd = '0; m_err = 0; m_retired = 0;
      return;
    end
    if (bus.FlushW) begin
      m_busy  = 0;
      m_valid = 0;
    end else if (!m_busy) begin
      m_valid = bus.ValidM; m_rw = bus.RegWriteM; m_mtr = bus.MemtoRegM;
      m_pc = bus.PCSrcM; m_wa3 = bus.WA3M; m_alu = bus.ALUOutM;
      if (bus.ValidM && bus.MemtoRegM && !bus.MemRValidM) begin
        m_busy   = 1;
        m_waited = 0;
      end else begin
        m_rd = bus.ReadDataM;
      end
    end else if (bus.MemRValidM) begin
      m_rd   = bus.ReadDataM;
      m_busy = 0;
    end else if (m_waited + 1 == TIMEOUT) begin
      m_err   = 1;
      m_valid = 0;
      m_busy  = 0;
    end else begin
      m_waited++;
    end
    if (m_valid && !m_busy) m_retired++;
  endtask

  task automatic check_model(input string tag);
    bit comp;
    comp = m_valid && !m_busy;
    check({tag, ".stall"},    32'(bus.StallW),    32'(m_busy));
    check({tag, ".regwrite"}, 32'(bus.RegWriteW), 32'(comp && m_rw));
    check({tag, ".wa3"},      32'(bus.WA3W),      32'(m_wa3));
    check({tag, ".result"},   32'(bus.ResultW),   32'(m_mtr ? m_rd : m_alu));
    check({tag, ".pcsrc"},    32'(bus.PCSrcW),    32'(comp && (m_pc || (m_rw && m_wa3 == 4'hF))));
    check({tag, ".retired"},  32'(bus.RetiredW),  32'(m_retired % (1 << CNTW)));
    check({tag, ".err"},      32'(bus.ErrW),      32'(m_err));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    int unsigned r0;
    drive(0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 0, 0, 1);
    cycle("reset");
    cycle("reset");
    check("reset_retired", 32'(bus.RetiredW), 32'd0);
    check("reset_stall",   32'(bus.StallW),   32'd0);

    // ALU write
    drive(1, 1, 0, 0, 4'd3, 8'h5A, 8'h00, 0, 0, 0);
    cycle("alu");
    check("alu_rw",      32'(bus.RegWriteW), 32'd1);
    check("alu_wa3",     32'(bus.WA3W),      32'd3);
    check("alu_result",  32'(bus.ResultW),   32'h5A);
    check("alu_retired", 32'(bus.RetiredW),  32'd1);

    // Ready load
    drive(1, 1, 1, 0, 4'd7, 8'h00, 8'hC3, 1, 0, 0);
    cycle("rload");
    check("rload_result", 32'(bus.ResultW), 32'hC3);
    check("rload_stall",  32'(bus.StallW),  32'd0);

    // Slow load: three stall cycles, then the response
    drive(1, 1, 1, 0, 4'd5, 8'h22, 8'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle("sload_wait");
      check("sload_stall", 32'(bus.StallW),    32'd1);
      check("sload_norw",  32'(bus.RegWriteW), 32'd0);
    end
    drive(1, 1, 1, 0, 4'd5, 8'h22, 8'h11, 1, 0, 0);
    cycle("sload_resp");
    check("sload_result", 32'(bus.ResultW),   32'h11);
    check("sload_rw",     32'(bus.RegWriteW), 32'd1);
    check("sload_nostl",  32'(bus.StallW),    32'd0);
    drive(1, 1, 0, 0, 4'd2, 8'h33, 8'h00, 0, 0, 0);
    cycle("after_sload");
    check("next_result", 32'(bus.ResultW), 32'h33);

    // Flush together with the memory response
    r0 = m_retired;
    drive(1, 1, 1, 0, 4'd6, 8'h00, 8'h00, 0, 0, 0);
    cycle("flush_wait");
    drive(1, 1, 1, 0, 4'd6, 8'h00, 8'h99, 1, 1, 0);
    cycle("flush");
    check("flush_stall",   32'(bus.StallW),    32'd0);
    check("flush_rw",      32'(bus.RegWriteW), 32'd0);
    check("flush_retired", 32'(bus.RetiredW),  32'(r0));
    check("flush_err",     32'(bus.ErrW),      32'd0);

    // Load timeout
    r0 = m_retired;
    drive(1, 1, 1, 0, 4'd9, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      cycle("tmo_wait");
      check("tmo_stall", 32'(bus.StallW),    32'd1);
      check("tmo_norw",  32'(bus.RegWriteW), 32'd0);
    end
    cycle("tmo");
    check("tmo_err",     32'(bus.ErrW),      32'd1);
    check("tmo_nostall", 32'(bus.StallW),    32'd0);
    check("tmo_rw",      32'(bus.RegWriteW), 32'd0);
    check("tmo_retired", 32'(bus.RetiredW),  32'(r0));

    // Write to R15 redirects the PC
    drive(1, 1, 0, 0, 4'hF, 8'h40, 8'h00, 0, 0, 0);
    cycle("pc");
    check("pc_pcsrc",  32'(bus.PCSrcW),  32'd1);
    check("pc_result", 32'(bus.ResultW), 32'h40);

    // Reset in the middle of a stalled load
    drive(1, 1, 1, 0, 4'd4, 8'h77, 8'h00, 0, 0, 0);
    cycle("rst_wait");
    drive(1, 1, 1, 0, 4'd4, 8'h77, 8'h55, 1, 0, 1);
    cycle("rst_mid");
    check("rstm_stall",   32'(bus.StallW),    32'd0);
    check("rstm_rw",      32'(bus.RegWriteW), 32'd0);
    check("rstm_wa3",     32'(bus.WA3W),      32'd0);
    check("rstm_result",  32'(bus.ResultW),   32'd0);
    check("rstm_retired", 32'(bus.RetiredW),  32'd0);
    check("rstm_err",     32'(bus.ErrW),      32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, 4'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; the producer side of the register-file write port that the decode stage consumes.
- Holds the M/W pipeline register and selects the result (ALU output or load data).
- Drives RegWriteW/WA3W/ResultW into the register file and PCSrcW to fetch.
- Absorbs variable-latency data-memory responses with a wait FSM and stall handshake, plus a retire counter and load-timeout watchdog.

Parameters:
- WIDTH, 8, datapath width of ALUOutM/ReadDataM/ResultW
- TIMEOUT, 16, max cycles spent in WAIT_MEM before the load is dropped (≥2)
- CNTW, 16, retired-instruction counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ValidM  in  1  M stage holds a real instruction
- RegWriteM  in  1  instruction writes a register
- MemtoRegM  in  1  result comes from data memory (load)
- PCSrcM  in  1  instruction redirects PC
- WA3M  in  4  destination register
- ALUOutM  in  WIDTH  ALU result
- ReadDataM  in  WIDTH  data-memory read data
- MemRValidM  in  1  ReadDataM valid this cycle
- FlushW  in  1  hazard-unit kill of W contents
- StallW  out  1  hold M and earlier stages
- RegWriteW  out  1  register-file write enable
- WA3W  out  4  write address
- ResultW  out  WIDTH  write data
- PCSrcW  out  1  PC redirect from writeback
- RetiredW  out  CNTW  instructions completed
- ErrW  out  1  sticky load-timeout flag

Behaviour:
- Reset (synchronous, active-high): state=IDLE, W register valid=0, all outputs 0, RetiredW=0, ErrW=0, watchdog=0.
- States: IDLE, WAIT_MEM. StallW = (state==WAIT_MEM); it is a Moore output with no combinational path from inputs.
- IDLE: every edge captures the M fields into the W register (valid=ValidM).
  - If ValidM & MemtoRegM & !MemRValidM, go to WAIT_MEM and clear the watchdog.
  - Otherwise also capture ReadDataM.
- WAIT_MEM: M inputs are not captured (upstream is held by StallW).
  - On MemRValidM: capture ReadDataM, go to IDLE.
  - Otherwise increment the watchdog.
  - When the watchdog reaches TIMEOUT-1 with no response: set ErrW, clear W valid, go to IDLE. The load is dropped with no write.
- Outputs are derived from the W register and are valid the whole cycle (the register file writes on the opposite edge):
  - complete = validW & (state==IDLE)
  - RegWriteW = complete & RegWriteW_reg
  - ResultW = MemtoReg ? ReadDataW : ALUOutW; selected through the existing mux2to1
  - WA3W = WA3W_reg
  - PCSrcW = complete & (PCSrc | (RegWrite & WA3==4'hF))
- Latency:
  - Non-load or ready load: 1 cycle, M capture to W outputs.
  - Stalled load: outputs appear the cycle after MemRValidM.
  - Stalled load costs StallW cycles plus one bubble.
- RetiredW increments by 1 on every complete cycle (including complete instructions with RegWrite=0) and wraps at 2^CNTW.
- FlushW: clears W valid and forces IDLE at the edge, including mid-WAIT_MEM. It overrides MemRValidM and the timeout in the same cycle. Nothing is written or counted.
- MemRValidM while IDLE with a non-load, or with ValidM=0: ignored.
- Reset mid-WAIT_MEM: full reset values; any pending response is ignored.
- ErrW is cleared only by reset.

Decomposition:
- Package wb_pkg:
  - wb_state_t enum {IDLE, WAIT_MEM}
  - R15 = 4'hF
  - W-register struct {valid, RegWrite, MemtoReg, PCSrc, WA3, ALUOut, ReadData}
  - TIMEOUT default
- One sub-module, wb_watchdog: counter with clear/enable/expire output, width $clog2(TIMEOUT).
- Result select reuses mux2to1.

Test Plan:
- ALU write: ValidM=1, RegWriteM=1, WA3M=3, ALUOutM=8'h5A → next cycle RegWriteW=1, WA3W=3, ResultW=8'h5A, RetiredW=1, StallW=0.
- Ready load: MemtoRegM=1, MemRValidM=1, ReadDataM=8'hC3, WA3M=7 → next cycle ResultW=8'hC3, RegWriteW=1, no stall.
- Slow load: MemtoRegM=1, MemRValidM low for 3 cycles then high with 8'h11:
  - StallW=1 for 3 cycles, RegWriteW=0 throughout the wait.
  - Cycle after response: ResultW=8'h11, RegWriteW=1, StallW=0.
  - The next M instruction is captured the following cycle.
- Timeout (TIMEOUT=4): load with MemRValidM never asserted → StallW high 4 cycles, then ErrW=1, RegWriteW never 1, RetiredW unchanged.
- Flush vs response: in WAIT_MEM assert FlushW and MemRValidM together → state IDLE, no write, RetiredW unchanged, ErrW=0.
- PC write: RegWriteM=1, WA3M=15, ALUOutM=8'h40 → PCSrcW=1, ResultW=8'h40. Reset asserted in the same later cycle as a stalled load → all outputs 0 next cycle.
